ram_scan_reader: RTL
====================

Name: ram_scan_reader

Overview:
- Autonomous read side for the 32x8 ramlpm: walks an address window, reads each byte, and holds address and data for the HEX decoders for a fixed dwell time.
- Replaces manual switch addressing when the memory contents must be inspected.
- Sits between board inputs (SW/KEY) and the ramlpm read port. It never writes, so ram_wren is tied low.

Parameters:
- ADDR_W, 5, RAM address width (32 words).
- DATA_W, 8, RAM word width.
- RD_LATENCY, 1, cycles from the address-latching edge to valid q; legal range 1..3.
- DWELL_CYCLES, 25000000, display hold per word (0.5 s at 50 MHz); minimum 2.

Ports:
- CLOCK_50  in  1  system clock; every register is on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a scan. Ignored while busy.
- stop  in  1  level; aborts the scan.
- pause  in  1  level; freezes the dwell counter.
- step_mode  in  1  1 = advance only on step. 0 = advance on dwell expiry.
- step  in  1  one-cycle pulse; advances in step_mode.
- loop_en  in  1  1 = restart at first_addr after last_addr.
- first_addr  in  ADDR_W  window start; sampled on start.
- last_addr  in  ADDR_W  window end, inclusive; sampled on start.
- ram_addr  out  ADDR_W  address to ramlpm.
- ram_wren  out  1  constant 0.
- ram_q  in  DATA_W  ramlpm data output.
- disp_addr  out  ADDR_W  address of the displayed word.
- disp_data  out  DATA_W  displayed word.
- data_valid  out  1  one-cycle pulse when disp_* update.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal scan completion.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - ram_addr, disp_addr, disp_data = 0.
  - data_valid, busy, done = 0.
  - cur, first and last registers = 0; dwell counter = 0.
- ram_addr is the registered cur address (no combinational path).
- FSM: IDLE -> ISSUE -> WAIT -> CAPTURE -> DWELL -> (ISSUE | IDLE).
- IDLE:
  - A start pulse latches first and last and sets cur=first.
  - Next state is ISSUE.
- ISSUE: one cycle; ramlpm latches ram_addr at the end of it.
- WAIT: RD_LATENCY cycles.
- CAPTURE (one cycle):
  - Registers disp_addr<=cur and disp_data<=ram_q.
  - data_valid is high in the following cycle.
- DWELL:
  - Counter loads DWELL_CYCLES-1 on entry and decrements per cycle while pause=0; it holds while pause=1.
  - With step_mode=1 the counter is ignored; exit happens on the first step pulse seen in DWELL. Step pulses outside DWELL are dropped.
- Exit from DWELL:
  - cur!=last: cur<=cur+1, which wraps naturally from 31 to 0. Next state is ISSUE.
  - cur==last and loop_en=1: cur<=first. Next state is ISSUE.
  - cur==last and loop_en=0: done pulses 1 cycle. Next state is IDLE.
- Window order: first>last is legal and scans through the wrap, e.g. 30,31,0,1. first==last scans one word.
- Latency: start sampled at edge k -> data_valid high in cycle k+2+RD_LATENCY.
- stop=1 in any non-IDLE state:
  - Next state is IDLE; done is not pulsed.
  - disp_* keep their last values.
  - stop has priority over step, dwell expiry and start.
- start while busy has no effect. start together with stop in IDLE has no effect.
- Window inputs changed mid-scan have no effect until the next start.

Optional Feature:
- Macro RAM_SCAN_CHECKSUM_EN.
- When defined:
  - Adds output checksum[DATA_W-1:0] and output checksum_valid (1-bit pulse).
  - checksum is the modulo-2^DATA_W sum of every byte captured in the current pass. It clears on start and at each loop restart.
  - checksum_valid pulses together with done, or at each loop wrap.
  - Both reset to 0.
- When undefined: neither port nor its logic exists.

Decomposition:
- Package ram_scan_pkg holds:
  - ADDR_W and DATA_W defaults.
  - The state enum typedef (IDLE, ISSUE, WAIT, CAPTURE, DWELL).
  - The wait-counter width constant.
- One sub-module, dwell_timer: loadable down-counter with hold (pause) and an expiry flag.

Test Plan (DWELL_CYCLES=4, RD_LATENCY=1, RAM preloaded mem[i]=i*3):
- After reset: start with first=2, last=4, loop_en=0 -> three data_valid pulses with (2,06), (3,09), (4,0C); first pulse in cycle 3 after the start edge; then done pulses and busy drops.
- Wrap window: first=30, last=1 -> captured order 30,31,0,1 with data 5A,5D,00,03.
- Mid-dwell: assert pause for 10 cycles -> next data_valid delayed exactly 10 cycles. Assert stop -> busy=0 next cycle, no done, disp_* unchanged.
- step_mode=1: no advance for 100 cycles; one step pulse -> next address captured 2+RD_LATENCY cycles later. A step during ISSUE is ignored.
- loop_en=1, first=last=7 -> data_valid every 2+RD_LATENCY+DWELL_CYCLES cycles with (7,15); a start pulse while busy changes nothing.
- With RAM_SCAN_CHECKSUM_EN defined, window 0..3 -> checksum=0x12 with checksum_valid coincident with done. Assert RESET mid-DWELL -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ram_scan_reader_pkg.sv
// ram_scan_reader shared types and defaults.
// Holds the scan FSM state encoding and counter widths.
package ram_scan_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    // Wide enough to count up to the largest read latency (3).
    localparam int WAIT_CNT_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DWELL
    } state_t;

endpackage

// File: rtl/ram_scan_reader_dwell_timer.sv
// dwell_timer: loadable down-counter with hold and expiry flag.
// Expiry is reported only while running, so a held count never expires.
module dwell_timer #(
    parameter int CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_expire
);

    localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_zero;

    assign w_zero   = (r_cnt == '0);
    assign o_expire = i_run && w_zero;

    // Load on dwell entry, count down while running, hold otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_run && !w_zero) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/ram_scan_reader.sv
// ram_scan_reader: walks an address window of a 32x8 RAM for display.
// Optional running checksum output enabled by RAM_SCAN_CHECKSUM_EN.
module ram_scan_reader
    import ram_scan_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RD_LATENCY   = 1,
    parameter int DWELL_CYCLES = 25000000
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              step_mode,
    input  logic              step,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              data_valid,
    output logic              busy,
`ifdef RAM_SCAN_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
    output logic              checksum_valid,
`endif
    output logic              done
);

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0]     r_cur;
    logic [ADDR_W-1:0]     r_first;
    logic [ADDR_W-1:0]     r_last;
    logic [ADDR_W-1:0]     r_disp_addr;
    logic [DATA_W-1:0]     r_disp_data;
    logic                  r_valid;
    logic                  r_done;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;

    logic w_busy;
    logic w_latch_win;
    logic w_capture;
    logic w_advance;
    logic w_finish;
    logic w_wrap;
    logic w_load;
    logic w_run;
    logic w_expire;
    logic w_wait_done;
    logic w_dwell_exit;
    logic w_at_last;

    assign w_wait_done  = (r_wait_cnt == WAIT_CNT_W'(RD_LATENCY - 1));
    assign w_at_last    = (r_cur == r_last);
    assign w_dwell_exit = step_mode ? step : w_expire;

    dwell_timer #(
        .CYCLES (DWELL_CYCLES)
    ) u_dwell (
        .i_clk    (CLOCK_50),
        .i_rst    (RESET),
        .i_load   (w_load),
        .i_run    (w_run),
        .o_expire (w_expire)
    );

    // State register.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; stop overrides everything outside IDLE.
    always_comb begin
        w_next = r_state;
        if (stop && (r_state != IDLE)) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start && !stop) w_next = ISSUE;
                ISSUE:   w_next = WAIT;
                WAIT:    if (w_wait_done) w_next = CAPTURE;
                CAPTURE: w_next = DWELL;
                DWELL: begin
                    if (w_dwell_exit) begin
                        w_next = (w_at_last && !loop_en) ? IDLE : ISSUE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Per-state control strobes for the datapath.
    always_comb begin
        w_busy      = (r_state != IDLE);
        w_latch_win = 1'b0;
        w_capture   = 1'b0;
        w_advance   = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            IDLE:    w_latch_win = start && !stop;
            CAPTURE: w_capture   = !stop;
            DWELL: begin
                w_run     = !pause;
                w_advance = w_dwell_exit && !stop;
            end
            default: ;
        endcase
        w_load   = w_capture;
        w_finish = w_advance && w_at_last && !loop_en;
        w_wrap   = w_advance && w_at_last && loop_en;
    end

    // Counts the read-latency cycles spent in WAIT.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_wait_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Window, current address and display registers.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_first     <= '0;
            r_last      <= '0;
            r_cur       <= '0;
            r_disp_addr <= '0;
            r_disp_data <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_valid <= w_capture;
            r_done  <= w_finish;
            if (w_latch_win) begin
                r_first <= first_addr;
                r_last  <= last_addr;
                r_cur   <= first_addr;
            end else if (w_advance) begin
                r_cur <= w_at_last ? r_first : r_cur + 1'b1;
            end
            if (w_capture) begin
                r_disp_addr <= r_cur;
                r_disp_data <= ram_q;
            end
        end
    end

`ifdef RAM_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic              r_sum_clr;
    logic              r_sum_valid;

    // Pass checksum: holds the full-pass total while checksum_valid
    // pulses at a loop wrap, then restarts with the next capture.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_sum       <= '0;
            r_sum_clr   <= 1'b0;
            r_sum_valid <= 1'b0;
        end else begin
            r_sum_valid <= w_finish || w_wrap;
            if (w_latch_win) begin
                r_sum     <= '0;
                r_sum_clr <= 1'b0;
            end else if (w_capture) begin
                r_sum     <= (r_sum_clr ? '0 : r_sum) + ram_q;
                r_sum_clr <= 1'b0;
            end else if (w_wrap) begin
                r_sum_clr <= 1'b1;
            end
        end
    end

    assign checksum       = r_sum;
    assign checksum_valid = r_sum_valid;
`endif

    assign ram_addr   = r_cur;
    assign ram_wren   = 1'b0;
    assign disp_addr  = r_disp_addr;
    assign disp_data  = r_disp_data;
    assign data_valid = r_valid;
    assign done       = r_done;
    assign busy       = w_busy;

endmodule
